// File: rtl/press_classifier.sv
// Turns the debounced button level and press tick into one-cycle short-press,
// long-press and double-click events, using one shared interval counter.
module press_classifier #(
   parameter int LONG_CYCLES   = 50_000_000,
   parameter int DCLICK_CYCLES = 12_500_000,
   parameter int CNT_W         = 26
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic level_i,
   input  logic tick_i,
   output logic short_o,
   output logic long_o,
   output logic double_o,
   output logic busy_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      PRESS1 = 2'b01,
      WAIT2  = 2'b10,
      HOLD   = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] DCLICK_TC = CNT_W'(DCLICK_CYCLES - 1);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             level_q;
   logic             release_s;
   logic             short_s;
   logic             long_s;
   logic             double_s;
   logic             short_r;
   logic             long_r;
   logic             double_r;
   logic             busy_r;

   assign release_s = level_q & ~level_i;

   // Next-state, counter and event decode; release beats terminal count in PRESS1,
   // tick beats terminal count in WAIT2.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      short_s     = 1'b0;
      long_s      = 1'b0;
      double_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (tick_i) begin
               state_nxt_s = PRESS1;
               cnt_nxt_s   = '0;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         PRESS1: begin
            if (release_s) begin
               state_nxt_s = WAIT2;
               cnt_nxt_s   = '0;
            end else if (cnt_r == LONG_TC) begin
               state_nxt_s = HOLD;
               long_s      = 1'b1;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_W'(1);
            end
         end
         WAIT2: begin
            if (tick_i) begin
               state_nxt_s = HOLD;
               double_s    = 1'b1;
            end else if (cnt_r == DCLICK_TC) begin
               state_nxt_s = IDLE;
               short_s     = 1'b1;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_W'(1);
            end
         end
         HOLD: begin
            if (release_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = HOLD;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
         end
      endcase
   end

   // State, counter, previous level and registered event outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r  <= IDLE;
         cnt_r    <= '0;
         level_q  <= 1'b0;
         short_r  <= 1'b0;
         long_r   <= 1'b0;
         double_r <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         cnt_r    <= cnt_nxt_s;
         level_q  <= level_i;
         short_r  <= short_s;
         long_r   <= long_s;
         double_r <= double_s;
         busy_r   <= (state_nxt_s != IDLE);
      end
   end

   assign short_o  = short_r;
   assign long_o   = long_r;
   assign double_o = double_r;
   assign busy_o   = busy_r;

endmodule

// File: tb/tb_press_classifier.sv
// Scoreboard bench for press_classifier: gestures are generated with known hold
// and gap lengths, the expected event and its edge are queued, a monitor checks.
module tb_press_classifier;

   localparam int LC = 8;
   localparam int DC = 5;
   localparam int CW = 4;

   localparam int K_SHORT  = 0;
   localparam int K_LONG   = 1;
   localparam int K_DOUBLE = 2;

   logic clk_i   = 1'b0;
   logic rst_ni  = 1'b0;
   logic level_i = 1'b0;
   logic tick_i  = 1'b0;
   logic short_o, long_o, double_o, busy_o;

   press_classifier #(
      .LONG_CYCLES  (LC),
      .DCLICK_CYCLES(DC),
      .CNT_W        (CW)
   ) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .level_i (level_i),
      .tick_i  (tick_i),
      .short_o (short_o),
      .long_o  (long_o),
      .double_o(double_o),
      .busy_o  (busy_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      int kind;
      int edge_n;
   } ev_t;
   ev_t exp_q[$];

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, got, want, cyc);
      end
   endtask

   // Monitor: every event pulse is matched against the head of the queue.
   always @(negedge clk_i) begin
      int  kind;
      ev_t e;
      if (short_o | long_o | double_o) begin
         kind = short_o ? K_SHORT : (long_o ? K_LONG : K_DOUBLE);
         check("one_hot_events", $countones({short_o, long_o, double_o}), 1);
         if (exp_q.size() == 0) begin
            check("unexpected_event", kind + 10, -1);
         end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_edge", cyc, e.edge_n);
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input int kind, input int edge_n);
      ev_t e;
      e.kind   = kind;
      e.edge_n = edge_n;
      exp_q.push_back(e);
   endtask

   // One gesture: first press with h high cycles; optional second tick after gap
   // idle cycles, held h2 cycles. Expected outcome derived from edge arithmetic.
   task automatic gesture(input int h, input bit early, input bit dbl, input int gap,
                          input bit early2, input int h2);
      int  t;
      int  r;
      bit  is_long;
      step();
      tick_i  = 1'b1;
      level_i = early ? 1'b0 : 1'b1;
      t       = cyc + 1;
      r       = t + h + 1;
      is_long = (r - t) > LC;
      if (is_long)  push(K_LONG, t + LC);
      else if (dbl) push(K_DOUBLE, r + gap + 1);
      else          push(K_SHORT, r + DC);
      step();
      tick_i  = 1'b0;
      level_i = 1'b1;
      check("busy_rise", int'(busy_o), 1);
      repeat (h - 1) step();
      step();
      level_i = 1'b0;
      if (dbl && !is_long) begin
         repeat (gap) step();
         step();
         tick_i  = 1'b1;
         level_i = early2 ? 1'b0 : 1'b1;
         step();
         tick_i  = 1'b0;
         level_i = 1'b1;
         check("busy_second", int'(busy_o), 1);
         repeat (h2 - 1) step();
         step();
         level_i = 1'b0;
      end
      repeat (DC + 4) step();
      check("busy_idle", int'(busy_o), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held while inputs toggle: outputs must stay quiet.
      for (int i = 0; i < 10; i++) begin
         step();
         level_i = 1'($urandom_range(0, 1));
         tick_i  = 1'($urandom_range(0, 1));
         check("reset_outputs", int'({short_o, long_o, double_o, busy_o}), 0);
      end
      tick_i  = 1'b0;
      level_i = 1'b0;
      step();
      rst_ni = 1'b1;
      repeat (3) step();
      check("busy_after_reset", int'(busy_o), 0);

      gesture(3, 1'b0, 1'b0, 0, 1'b0, 1);    // short press
      gesture(20, 1'b1, 1'b0, 0, 1'b0, 1);   // long press
      gesture(2, 1'b0, 1'b1, 2, 1'b1, 4);    // double click, tick 3 after release
      gesture(7, 1'b0, 1'b0, 0, 1'b0, 1);    // release tie at cnt=7 -> short
      gesture(8, 1'b0, 1'b0, 0, 1'b0, 1);    // one cycle longer -> long
      gesture(1, 1'b1, 1'b1, 4, 1'b0, 3);    // second tick tie at cnt=4 -> double

      // Reset during WAIT2: that gesture must never emit anything.
      step();
      tick_i  = 1'b1;
      level_i = 1'b1;
      step();
      tick_i  = 1'b0;
      step();
      step();
      level_i = 1'b0;
      step();
      step();
      check("busy_wait2", int'(busy_o), 1);
      rst_ni = 1'b0;
      #1;
      check("async_reset_busy", int'(busy_o), 0);
      check("async_reset_events", int'({short_o, long_o, double_o}), 0);
      repeat (2) step();
      rst_ni = 1'b1;
      repeat (10) step();
      gesture(2, 1'b0, 1'b0, 0, 1'b0, 1);

      for (int g = 0; g < 40; g++) begin
         gesture(int'($urandom_range(1, 14)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                 1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
      end

      repeat (5) step();
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
